aes_decrypt_core: RTL and testbench

Iterative AES-128 decryption core. It is the inverse of the existing encryption datapath and sits beside it on the co-processor bus.
- Accepts a 128-bit cipher key and ciphertext on a start pulse.
- Expands the key forward on the fly to the last round key, then walks the rounds backwards using inverse key expansion.
- Returns the plaintext with a one-cycle done pulse.
- Contains its own control FSM, round counter and round-key register. The InvSubBytes, InvShiftRows and InvMixColumns stages are instantiated as separate combinational submodules.

---
 rtl/aes_decrypt_core.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_aes_decrypt_core.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_core.sv
// ============================================================================
// aes_decrypt_core : iterative AES-128 decryption with on-the-fly inverse key
//                    expansion. Optional key cache: AES_KEY_CACHE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_decrypt_core_pkg;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, which also maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 7; i++) r = gf_mul(gf_mul(r, r), a);
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input int i);
    case (i)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w4, w5, w6, w7;
    w4 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h000000};
    w5 = k[95:64] ^ w4;
    w6 = k[63:32] ^ w5;
    w7 = k[31:0] ^ w6;
    return {w4, w5, w6, w7};
  endfunction

  // Recovers the previous round key; w3 must be rebuilt before w0 can be.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

endpackage

module aes_inv_shift_rows (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  // Byte r+4c (row r, column c) comes from column (c-r) mod 4 of the same row.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign data_o[127-8*(r+4*c) -: 8] = data_i[127-8*(r+4*((c-r+4)%4)) -: 8];
    end
  end
endmodule

module aes_inv_sub_bytes (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  for (genvar i = 0; i < 16; i++) begin : g_byte
    assign data_o[127-8*i -: 8] = aes_decrypt_core_pkg::inv_sbox(data_i[127-8*i -: 8]);
  end
endmodule

module aes_inv_mix_columns (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign data_o[127-32*c -: 32] = aes_decrypt_core_pkg::inv_mix_col(data_i[127-32*c -: 32]);
  end
endmodule

module aes_decrypt_core #(
  parameter int NR    = 10,
  parameter int CNT_W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] cipher_text_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] Dout
);
  import aes_decrypt_core_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NR - 1);

  typedef enum logic [2:0] {
    IDLE, KEYEXP, ADD0, INV_SRSB, ADD_KEY, INV_MC, FINAL
  } state_e;

  state_e             fsm_q, fsm_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [127:0]       key_q, key_d;
  logic [127:0]       st_q, st_d;
  logic [127:0]       dout_q, dout_d;
  logic               busy_q, done_q;
  logic [127:0]       shifted, subbed, mixed;
  logic               cache_hit;
  logic [127:0]       cache_key;

  aes_inv_shift_rows  u_inv_shift_rows  (.data_i(st_q),    .data_o(shifted));
  aes_inv_sub_bytes   u_inv_sub_bytes   (.data_i(shifted), .data_o(subbed));
  aes_inv_mix_columns u_inv_mix_columns (.data_i(st_q),    .data_o(mixed));

  always_comb begin
    fsm_d   = fsm_q;
    count_d = count_q;
    key_d   = key_q;
    st_d    = st_q;
    dout_d  = dout_q;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          st_d    = cipher_text_in;
          count_d = '0;
          if (cache_hit) begin
            key_d = cache_key;
            fsm_d = ADD0;
          end else begin
            key_d = key_in;
            fsm_d = KEYEXP;
          end
        end
      end
      KEYEXP: begin
        key_d   = key_fwd(key_q, rcon(int'(count_q) + 1));
        count_d = count_q + 1'b1;
        if (count_q == LAST_CNT) fsm_d = ADD0;
      end
      ADD0: begin
        st_d    = st_q ^ key_q;
        key_d   = key_inv(key_q, rcon(NR));
        count_d = LAST_CNT;
        fsm_d   = INV_SRSB;
      end
      INV_SRSB: begin
        st_d  = subbed;
        fsm_d = (count_q == '0) ? FINAL : ADD_KEY;
      end
      ADD_KEY: begin
        st_d  = st_q ^ key_q;
        key_d = key_inv(key_q, rcon(int'(count_q)));
        fsm_d = INV_MC;
      end
      INV_MC: begin
        st_d    = mixed;
        count_d = count_q - 1'b1;
        fsm_d   = INV_SRSB;
      end
      FINAL: begin
        dout_d = st_q ^ key_q;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q   <= IDLE;
      count_q <= '0;
      key_q   <= '0;
      st_q    <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      count_q <= count_d;
      key_q   <= key_d;
      st_q    <= st_d;
      dout_q  <= dout_d;
      // busy skips the first working cycle and is already low in the done cycle.
      busy_q  <= (fsm_q != IDLE) && (fsm_q != FINAL);
      done_q  <= (fsm_q == FINAL);
    end
  end

`ifdef AES_KEY_CACHE_EN
  logic [127:0] last_key_q, last_key_d;
  logic [127:0] cache_key_q, cache_key_d;
  logic         cache_valid_q, cache_valid_d;

  assign cache_hit = cache_valid_q && (key_in == last_key_q);
  assign cache_key = cache_key_q;

  // The cache only becomes valid once a full forward expansion has finished.
  always_comb begin
    last_key_d    = last_key_q;
    cache_key_d   = cache_key_q;
    cache_valid_d = cache_valid_q;
    if (fsm_q == IDLE && start && !cache_hit) begin
      last_key_d    = key_in;
      cache_valid_d = 1'b0;
    end
    if (fsm_q == KEYEXP && count_q == LAST_CNT) begin
      cache_key_d   = key_d;
      cache_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_key_q    <= '0;
      cache_key_q   <= '0;
      cache_valid_q <= 1'b0;
    end else begin
      last_key_q    <= last_key_d;
      cache_key_q   <= cache_key_d;
      cache_valid_q <= cache_valid_d;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_key = '0;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign Dout = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_aes_decrypt_core.sv
// ============================================================================
// tb_aes_decrypt_core : scoreboard bench for aes_decrypt_core (FIPS-197 vectors)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aes_decrypt_core;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K3 = 128'h0;
  localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] P3 = 128'h0;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] cipher_text_in = '0;
  logic         busy;
  logic         done;
  logic [127:0] Dout;

  aes_decrypt_core dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .key_in         (key_in),
    .cipher_text_in (cipher_text_in),
    .busy           (busy),
    .done           (done),
    .Dout           (Dout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [127:0] pt;
    int           due;
    int           lat;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           ready_cyc = 0;
  int           n_acc = 0;
  int           busy_cnt = 0;
  logic [127:0] cur_pt = '0;
  logic [127:0] m_dout = '0;
  logic [127:0] m_last_key = '0;
  logic         m_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: model acceptance at the edge, then check outputs 1 time unit later.
  task automatic step();
    logic         acc;
    logic [127:0] acc_key;
    int           lat;
    exp_t         e;
    acc     = start && reset && (cyc >= ready_cyc);
    acc_key = key_in;
    @(posedge clock);
    cyc++;
    if (acc) begin
      lat = 40;
`ifdef AES_KEY_CACHE_EN
      if (m_valid && acc_key == m_last_key) lat = 30;
`endif
      m_valid    = 1'b1;
      m_last_key = acc_key;
      e.pt  = cur_pt;
      e.due = cyc + lat;
      e.lat = lat;
      sb.push_back(e);
      ready_cyc = cyc + lat;
      n_acc++;
    end
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      m_dout = e.pt;
      check_eq("done_pulse", done, 1);
      check_eq("busy_in_done", busy, 0);
      check_eq("busy_cycles", busy_cnt, e.lat - 1);
      busy_cnt = 0;
    end else begin
      check_eq("no_done", done, 0);
      if (busy) busy_cnt++;
    end
    check_eq("dout", Dout, m_dout);
  endtask

  task automatic wait_accept(input int target);
    for (int i = 0; i < 100 && n_acc < target; i++) step();
    check_eq("accept_timeout", n_acc, target);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb.size() > 0; i++) step();
    check_eq("drain_timeout", sb.size(), 0);
  endtask

  task automatic drive(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
    key_in         = k;
    cipher_text_in = c;
    cur_pt         = p;
  endtask

  task automatic run_vec(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
    drive(k, c, p);
    start = 1'b1;
    wait_accept(n_acc + 1);
    start = 1'b0;
    wait_idle();
    repeat (2) step();
  endtask

  // Second start is accepted in the done cycle of the first run.
  task automatic run_pair(input logic [127:0] ka, input logic [127:0] ca, input logic [127:0] pa,
                          input logic [127:0] kb, input logic [127:0] cb, input logic [127:0] pb);
    int target;
    drive(ka, ca, pa);
    start  = 1'b1;
    target = n_acc + 1;
    wait_accept(target);
    drive(kb, cb, pb);
    wait_accept(target + 1);
    start = 1'b0;
    wait_idle();
    repeat (2) step();
  endtask

  initial begin
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_dout", Dout, 0);
    repeat (2) step();
    reset = 1'b1;
    repeat (2) step();

    // FIPS-197 C.1 and Appendix B
    run_vec(K1, C1, P1);
    run_vec(K2, C2, P2);

    // start held high, inputs changed mid-run, re-accepted in the done cycle
    drive(K1, C1, P1);
    start = 1'b1;
    wait_accept(n_acc + 1);
    repeat (20) step();
    drive(K2, C2, P2);
    wait_accept(n_acc + 1);
    start = 1'b0;
    wait_idle();
    repeat (2) step();

    // reset 20 cycles into a run
    drive(K1, C1, P1);
    start = 1'b1;
    wait_accept(n_acc + 1);
    start = 1'b0;
    repeat (19) step();
    reset = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_dout", Dout, 0);
    sb.delete();
    m_dout    = '0;
    m_valid   = 1'b0;
    busy_cnt  = 0;
    ready_cyc = 0;
    repeat (2) step();
    reset = 1'b1;
    repeat (25) step();
    run_vec(K2, C2, P2);

    // back-to-back runs, then a repeated key
    run_pair(K1, C1, P1, K2, C2, P2);
    run_pair(K1, C1, P1, K1, C1, P1);

    // all-zero key
    run_vec(K3, C3, P3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
